// File: rtl/sp_ram_arb_pkg.sv
// sp_ram_arb_pkg: shared state type, id width helper and lock timeout default
package sp_ram_arb_pkg;
    typedef enum logic {IDLE, LOCKED} arb_state_e;
    localparam int LOCK_MAX_DEF = 16;
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sp_ram_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);
    // Scan from the farthest slot back toward ptr so the nearest request wins last
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                gnt = '0;
                gnt[(int'(ptr) + k) % NREQ] = 1'b1;
                idx = IW'((int'(ptr) + k) % NREQ);
            end
        end
    end
endmodule

// File: rtl/sp_ram_arbiter.sv
// sp_ram_arbiter: round-robin sharing of one write-first RAM port with atomic lock
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW = 8,
    parameter int WORDS = 256,
    parameter int LOCK_MAX = LOCK_MAX_DEF,
    localparam int AW = $clog2(WORDS),
    localparam int IW = id_width(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ-1:0]      req_lock,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_din,
    output logic                 rsp_valid,
    output logic [IW-1:0]        rsp_id,
    output logic                 rsp_we,
    output logic [DW-1:0]        rsp_data,
    output logic                 lock_abort,
    output logic [AW-1:0]        ram_addr,
    output logic                 ram_we,
    output logic [DW-1:0]        ram_din,
    input  logic [DW-1:0]        ram_qout
);
    localparam int CW = $clog2(LOCK_MAX + 1);

    arb_state_e      state_q;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d, lock_owner_q, g, arb_idx;
    logic [CW-1:0]   lock_cnt_q;
    logic [NREQ-1:0] arb_gnt;
    logic            rsp_valid_q, rsp_we_q, lock_abort_q, accept, unlock, timeout;
    logic [IW-1:0]   rsp_id_q;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req(req_valid),
        .ptr(rr_ptr_q),
        .gnt(arb_gnt),
        .idx(arb_idx)
    );

    // Grant selection and direct RAM drive; nothing is granted while reset is held
    always_comb begin
        g         = (state_q == LOCKED) ? lock_owner_q : arb_idx;
        req_ready = rst ? '0 : (state_q == LOCKED) ? (req_valid & (NREQ'(1) << lock_owner_q)) : arb_gnt;
        accept    = |req_ready;
        ram_addr  = accept ? req_addr[int'(g)*AW +: AW] : '0;
        ram_din   = accept ? req_din[int'(g)*DW +: DW] : '0;
        ram_we    = accept & req_we[g];
        rr_ptr_d  = (g == IW'(NREQ - 1)) ? '0 : g + 1'b1;
        unlock    = accept & ~req_lock[g];
        timeout   = lock_cnt_q == CW'(LOCK_MAX - 1);
    end

    // Arbitration state, lock timer and one-cycle response pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            lock_owner_q <= '0;
            lock_cnt_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_we_q     <= 1'b0;
            lock_abort_q <= 1'b0;
        end else begin
            rsp_valid_q  <= accept;
            rsp_we_q     <= ram_we;
            lock_abort_q <= 1'b0;
            if (accept) rsp_id_q <= g;
            if (state_q == IDLE) begin
                if (accept) begin
                    rr_ptr_q <= rr_ptr_d;
                    if (req_lock[g]) begin
                        state_q      <= LOCKED;
                        lock_owner_q <= g;
                        lock_cnt_q   <= '0;
                    end
                end
            end else begin
                lock_cnt_q <= lock_cnt_q + 1'b1;
                if (unlock || timeout) begin
                    state_q      <= IDLE;
                    rr_ptr_q     <= rr_ptr_d;
                    lock_abort_q <= ~unlock;
                end
            end
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_we     = rsp_we_q;
    assign lock_abort = lock_abort_q;
    assign rsp_data   = ram_qout;
endmodule

// File: tb/tb_sp_ram_arbiter.sv
// tb_sp_ram_arbiter: directed checks of grants, responses, locking and reset
module tb_sp_ram_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  v, we, lk, req_ready;
    logic [7:0]  a [4];
    logic [7:0]  d [4];
    logic [31:0] req_addr, req_din;
    logic        rsp_valid, rsp_we, lock_abort, ram_we;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data, ram_addr, ram_din, ram_q;
    logic [7:0]  mem [256];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign req_addr = {a[3], a[2], a[1], a[0]};
    assign req_din  = {d[3], d[2], d[1], d[0]};

    sp_ram_arbiter #(.NREQ(4), .DW(8), .WORDS(256), .LOCK_MAX(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(v), .req_ready(req_ready), .req_we(we), .req_lock(lk),
        .req_addr(req_addr), .req_din(req_din),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_we(rsp_we), .rsp_data(rsp_data),
        .lock_abort(lock_abort),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_qout(ram_q)
    );

    // Write-first single-port RAM, preloaded with addr ^ 0x5A
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_din;
            ram_q <= ram_din;
        end else ram_q <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with inputs set: checks grant, then the response after the edge
    task automatic cyc(input string tag, input logic [3:0] e_rdy, input logic e_rv,
                       input logic [1:0] e_id, input logic e_we, input logic [7:0] e_data);
        #1 chk({tag, "_ready"}, req_ready, e_rdy);
        @(posedge clk);
        #1 chk({tag, "_rsp_valid"}, rsp_valid, e_rv);
        if (e_rv) begin
            chk({tag, "_rsp_id"}, rsp_id, e_id);
            chk({tag, "_rsp_we"}, rsp_we, e_we);
            chk({tag, "_rsp_data"}, rsp_data, e_data);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] e1 [5];
        logic [7:0] e5 [5];
        e1 = '{8'h4A, 8'h4B, 8'h48, 8'h49, 8'h4A};
        e5 = '{8'h0A, 8'h0B, 8'h08, 8'h09, 8'h0E};
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        rst = 1'b1;
        v = '0; we = '0; lk = '0;
        for (int i = 0; i < 4; i++) begin a[i] = '0; d[i] = '0; end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_lock_abort", lock_abort, 0);
        chk("rst_ready", req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        // all four read continuously: rotation 0,1,2,3,0
        v = 4'b1111;
        for (int i = 0; i < 4; i++) a[i] = 8'h10 + 8'(i);
        for (int k = 0; k < 5; k++)
            cyc("rr", 4'b0001 << (k % 4), 1'b1, 2'(k % 4), 1'b0, e1[k]);
        v = '0;
        #1 chk("idle_ram_we", ram_we, 0);
        chk("idle_ram_addr", ram_addr, 0);
        cyc("idle", 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00);
        // write then read-back of the same address
        v = 4'b0010; we = 4'b0010; a[1] = 8'h20; d[1] = 8'hA5;
        #1 chk("wr_ram_we", ram_we, 1);
        chk("wr_ram_addr", ram_addr, 8'h20);
        chk("wr_ram_din", ram_din, 8'hA5);
        cyc("wr", 4'b0010, 1'b1, 2'd1, 1'b1, 8'hA5);
        v = 4'b0100; we = '0; a[2] = 8'h20;
        cyc("rd_after_wr", 4'b0100, 1'b1, 2'd2, 1'b0, 8'hA5);
        v = 4'b0010; a[1] = 8'h00;
        cyc("rr_wrap", 4'b0010, 1'b1, 2'd1, 1'b0, 8'h5A);
        // locked read-modify-write by req2 stalls req0/req3
        v = 4'b1101; a[0] = 8'h00; a[2] = 8'h30; a[3] = 8'h03; lk = 4'b0100;
        cyc("lock_rd", 4'b0100, 1'b1, 2'd2, 1'b0, 8'h6A);
        we = 4'b0100; lk = '0; a[2] = 8'h31; d[2] = 8'h77;
        cyc("lock_wr", 4'b0100, 1'b1, 2'd2, 1'b1, 8'h77);
        v = 4'b1001; we = '0;
        cyc("after_lock", 4'b1000, 1'b1, 2'd3, 1'b0, 8'h59);
        v = 4'b0001;
        cyc("after_lock2", 4'b0001, 1'b1, 2'd0, 1'b0, 8'h5A);
        // lock held idle until forced release
        v = 4'b0010; a[1] = 8'h40; lk = 4'b0010;
        cyc("lock_take", 4'b0010, 1'b1, 2'd1, 1'b0, 8'h1A);
        v = 4'b0001; lk = '0; a[0] = 8'h05;
        for (int k = 0; k < 15; k++) begin
            cyc("lock_hold", 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00);
            chk("abort_low", lock_abort, 0);
        end
        cyc("lock_last", 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00);
        chk("abort_pulse", lock_abort, 1);
        cyc("post_abort", 4'b0001, 1'b1, 2'd0, 1'b0, 8'h5F);
        chk("abort_clear", lock_abort, 0);
        // single requester back-to-back, pointer wraps to 0
        v = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            a[3] = 8'h50 + 8'(k);
            cyc("b2b", 4'b1000, 1'b1, 2'd3, 1'b0, e5[k]);
        end
        v = 4'b0111; a[0] = 8'h01; a[1] = 8'h01; a[2] = 8'h01;
        cyc("ptr_wrap", 4'b0001, 1'b1, 2'd0, 1'b0, 8'h5B);
        // asynchronous reset while locked with a response pending
        v = 4'b0010; a[1] = 8'h60; lk = 4'b0010;
        cyc("pre_rst", 4'b0010, 1'b1, 2'd1, 1'b0, 8'h3A);
        #1 rst = 1'b1; we = 4'b0010;
        #1 chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_ready", req_ready, 0);
        chk("arst_ram_we", ram_we, 0);
        chk("arst_abort", lock_abort, 0);
        @(negedge clk);
        rst = 1'b0; v = 4'b1001; we = '0; lk = '0; a[0] = 8'h02;
        cyc("post_rst", 4'b0001, 1'b1, 2'd0, 1'b0, 8'h58);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
